// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word sequencer: field map, word width and FSM encoding.
package ctrl_pkg;

    localparam int unsigned CW = 12;

    localparam int unsigned PCSRC_BIT    = 11;
    localparam int unsigned MEMTOREG_BIT = 10;
    localparam int unsigned MEMWRITE_BIT = 9;
    localparam int unsigned ALUCTL_LSB   = 7;
    localparam int unsigned ALUSRC_LSB   = 5;
    localparam int unsigned IMMSRC_LSB   = 3;
    localparam int unsigned REGWRITE_BIT = 2;
    localparam int unsigned REGSRC_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    typedef struct packed {
        logic       pcsrc;
        logic       memtoreg;
        logic       memwrite;
        logic [1:0] aluctl;
        logic [1:0] alusrc;
        logic [1:0] immsrc;
        logic       regwrite;
        logic [1:0] regsrc;
    } ctrl_word_t;

    function automatic ctrl_word_t decode_word(input logic [CW-1:0] w);
        ctrl_word_t f;
        f.pcsrc    = w[PCSRC_BIT];
        f.memtoreg = w[MEMTOREG_BIT];
        f.memwrite = w[MEMWRITE_BIT];
        f.aluctl   = w[ALUCTL_LSB +: 2];
        f.alusrc   = w[ALUSRC_LSB +: 2];
        f.immsrc   = w[IMMSRC_LSB +: 2];
        f.regwrite = w[REGWRITE_BIT];
        f.regsrc   = w[REGSRC_LSB +: 2];
        return f;
    endfunction

endpackage

// File: rtl/ctrl_word_ram.sv
// Control-word table: synchronous write, combinational read. Contents survive reset.
module ctrl_word_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_sequencer.sv
// Replays a programmable table of datapath control words, one word per cycle,
// with free-run, single-step and loop modes. Control outputs are zero outside RUN.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [CW-1:0] LdData,
    output logic          LdErr,
    input  logic          Start,
    input  logic [AW:0]   Len,
    input  logic          StepMode,
    input  logic          LoopEn,
    input  logic          Step,
    input  logic          Stop,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] CurAddr,
    output logic          PCSrc,
    output logic          MemtoReg,
    output logic          MemWrite,
    output logic [1:0]    ALUControl,
    output logic [1:0]    ALUSrc,
    output logic [1:0]    ImmSrc,
    output logic          RegWrite,
    output logic [1:0]    RegSrc
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] last_q;
    logic          step_mode_q;
    logic          loop_q;
    logic          lderr_q;
    logic [CW-1:0] word_q;

    logic          busy;
    logic          ram_we;
    logic          at_last;
    logic          adv_run;
    logic [AW:0]   len_sat;
    logic [AW-1:0] len_last;
    logic [AW-1:0] next_addr;
    logic [CW-1:0] rd_data;
    logic [CW-1:0] next_word;
    ctrl_word_t    fields;

    assign busy     = (state_q == StRun) || (state_q == StWait);
    assign ram_we   = LdEn && !busy && !RST;
    assign at_last  = (addr_q == last_q);
    assign adv_run  = !at_last || loop_q;
    assign len_sat  = (Len > DEPTH_W) ? DEPTH_W : Len;
    assign len_last = AW'(len_sat - (AW+1)'(1));

    // From IDLE the first word is entry 0; otherwise step forward, wrapping at the last entry.
    always_comb begin
        next_addr = '0;
        if (state_q != StIdle && !at_last) begin
            next_addr = addr_q + AW'(1);
        end
    end

    ctrl_word_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CW),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (LdAddr),
        .wdata (LdData),
        .raddr (next_addr),
        .rdata (rd_data)
    );

    // A write landing on the same edge as Start must be visible in the first issued word.
    assign next_word = (ram_we && (LdAddr == next_addr)) ? LdData : rd_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_q      <= '0;
            step_mode_q <= 1'b0;
            loop_q      <= 1'b0;
            lderr_q     <= 1'b0;
            word_q      <= '0;
        end else begin
            lderr_q <= LdEn && busy;
            word_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        step_mode_q <= StepMode;
                        loop_q      <= LoopEn;
                        last_q      <= len_last;
                        addr_q      <= '0;
                        if (len_sat == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StRun;
                            word_q  <= next_word;
                        end
                    end
                end
                StRun, StWait: begin
                    if (Stop) begin
                        state_q <= StIdle;
                        addr_q  <= '0;
                    end else if (state_q == StRun && step_mode_q) begin
                        state_q <= StWait;
                    end else if (state_q == StRun || Step) begin
                        if (adv_run) begin
                            state_q <= StRun;
                            addr_q  <= next_addr;
                            word_q  <= next_word;
                        end else begin
                            state_q <= StDone;
                            addr_q  <= '0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign fields     = decode_word(word_q);
    assign LdErr      = lderr_q;
    assign Busy       = busy;
    assign Done       = (state_q == StDone);
    assign CurAddr    = addr_q;
    assign PCSrc      = fields.pcsrc;
    assign MemtoReg   = fields.memtoreg;
    assign MemWrite   = fields.memwrite;
    assign ALUControl = fields.aluctl;
    assign ALUSrc     = fields.alusrc;
    assign ImmSrc     = fields.immsrc;
    assign RegWrite   = fields.regwrite;
    assign RegSrc     = fields.regsrc;

endmodule
